// File: rtl/vjtag_uart_bridge_if.sv
// Host-bus and Virtual JTAG signal bundle for the VJTAG UART bridge.
// The master side is the host/hub; the slave side is the bridge.
interface vjtag_uart_bridge_if #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic          nwr_i;
    logic [W-1:0]  data_i;
    logic          rd_i;
    logic [W-1:0]  data_o;
    logic          txmt;
    logic          txfl;
    logic          rxmt;
    logic          rxfl;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          rx_ovf;

    logic          vj_tck_i;
    logic          vj_tdi_i;
    logic [1:0]    vj_ir_i;
    logic          vj_cdr_i;
    logic          vj_sdr_i;
    logic          vj_udr_i;
    logic          vj_uir_i;
    logic [1:0]    vj_ir_o;
    logic          vj_tdo_o;

    modport master (
        output nwr_i, data_i, rd_i,
        output vj_tck_i, vj_tdi_i, vj_ir_i, vj_cdr_i, vj_sdr_i, vj_udr_i, vj_uir_i,
        input  data_o, txmt, txfl, rxmt, rxfl, tx_count, rx_count, rx_ovf,
        input  vj_ir_o, vj_tdo_o
    );

    modport slave (
        input  nwr_i, data_i, rd_i,
        input  vj_tck_i, vj_tdi_i, vj_ir_i, vj_cdr_i, vj_sdr_i, vj_udr_i, vj_uir_i,
        output data_o, txmt, txfl, rxmt, rxfl, tx_count, rx_count, rx_ovf,
        output vj_ir_o, vj_tdo_o
    );
endinterface

// File: rtl/vjtag_uart_bridge.sv
// Virtual JTAG <-> CoPro bus bridge: TX/RX FIFOs on clk_i, VJTAG inputs
// synchronised and TCK rising edges detected, so nothing runs on TCK.

// Word FIFO with registered fill count and empty/full flags.
module vjtag_uart_bridge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          do_push, do_pop;

    // Gating uses the registered flags, so a push into a full FIFO is
    // refused even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
endmodule

module vjtag_uart_bridge #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input logic               clk_i,
    input logic               nreset_i,
    vjtag_uart_bridge_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int STW = 5 + 2 * CW;
    localparam int S   = (W + 1 > STW) ? W + 1 : STW;

    typedef enum logic [1:0] {
        IR_TX     = 2'b00,
        IR_RX     = 2'b01,
        IR_STATUS = 2'b10,
        IR_BYPASS = 2'b11
    } ir_e;

    // {tck, tdi, ir[1:0], cdr, sdr, udr, uir}
    logic [7:0]    vj_raw, vj_s1_q, vj_s2_q;
    logic          tck_prev_q;
    logic          tck_s, tdi_s, cdr_s, sdr_s, udr_s, uir_s, tck_rise;
    logic [1:0]    ir_s;

    ir_e           ir_q, ir_d;
    logic [S-1:0]  sr_q, sr_d;
    logic          byp_q, byp_d;
    logic          ovf_q, ovf_d;
    logic          tdo_q, tdo_d;
    logic [W-1:0]  dout_q;

    logic          tx_pop, tx_empty, tx_full;
    logic          rx_push, rx_pop, rx_empty, rx_full;
    logic [W-1:0]  tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;

    assign vj_raw = {bus.vj_tck_i, bus.vj_tdi_i, bus.vj_ir_i, bus.vj_cdr_i,
                     bus.vj_sdr_i, bus.vj_udr_i, bus.vj_uir_i};
    assign {tck_s, tdi_s, ir_s, cdr_s, sdr_s, udr_s, uir_s} = vj_s2_q;
    assign tck_rise = tck_s & ~tck_prev_q;

    vjtag_uart_bridge_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_tx (
        .clk_i, .nreset_i,
        .push_i (~bus.nwr_i),
        .pop_i  (tx_pop),
        .wdata_i(bus.data_i),
        .head_o (tx_head),
        .count_o(tx_count),
        .empty_o(tx_empty),
        .full_o (tx_full)
    );

    assign rx_pop = bus.rd_i & ~rx_empty;

    vjtag_uart_bridge_fifo #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_rx (
        .clk_i, .nreset_i,
        .push_i (rx_push),
        .pop_i  (rx_pop),
        .wdata_i(sr_q[W-1:0]),
        .head_o (rx_head),
        .count_o(rx_count),
        .empty_o(rx_empty),
        .full_o (rx_full)
    );

    always_comb begin
        ir_d    = ir_q;
        sr_d    = sr_q;
        byp_d   = byp_q;
        ovf_d   = ovf_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        if (tck_rise) begin
            if (uir_s)
                ir_d = ir_e'(ir_s);
            if (cdr_s && ir_q == IR_TX) begin
                sr_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    sr_d[W:0]  = {1'b1, tx_head};
                end
            end
            if (cdr_s && ir_q == IR_STATUS) begin
                sr_d            = '0;
                sr_d[STW-1:0]   = {rx_count, tx_count, ovf_q, rx_full, rx_empty, tx_full, tx_empty};
                ovf_d           = 1'b0;
            end
            if (sdr_s) begin
                if (ir_q == IR_BYPASS) byp_d = tdi_s;
                else                   sr_d  = {tdi_s, sr_q[S-1:1]};
            end
            // Evaluated after the status clear so a same-cycle overflow sticks.
            if (udr_s && ir_q == IR_RX && sr_q[W]) begin
                if (rx_full) ovf_d   = 1'b1;
                else         rx_push = 1'b1;
            end
        end
        tdo_d = (ir_q == IR_BYPASS) ? byp_q : sr_q[0];
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            vj_s1_q    <= '0;
            vj_s2_q    <= '0;
            tck_prev_q <= 1'b0;
            ir_q       <= IR_BYPASS;
            sr_q       <= '0;
            byp_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tdo_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            vj_s1_q    <= vj_raw;
            vj_s2_q    <= vj_s1_q;
            tck_prev_q <= tck_s;
            ir_q       <= ir_d;
            sr_q       <= sr_d;
            byp_q      <= byp_d;
            ovf_q      <= ovf_d;
            tdo_q      <= tdo_d;
            if (rx_pop) dout_q <= rx_head;
        end
    end

    assign bus.data_o   = dout_q;
    assign bus.txmt     = tx_empty;
    assign bus.txfl     = tx_full;
    assign bus.rxmt     = rx_empty;
    assign bus.rxfl     = rx_full;
    assign bus.tx_count = tx_count;
    assign bus.rx_count = rx_count;
    assign bus.rx_ovf   = ovf_q;
    assign bus.vj_ir_o  = bus.vj_ir_i;
    assign bus.vj_tdo_o = tdo_q;
endmodule

// File: tb/tb_vjtag_uart_bridge.sv
// Scoreboard bench for vjtag_uart_bridge: host pushes and RX scans queue
// expected words; TX scans and host pops compare against them.
module tb_vjtag_uart_bridge;
    localparam int W     = 8;
    localparam int DEPTH = 64;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int STW   = 5 + 2 * CW;
    localparam int S     = (W + 1 > STW) ? W + 1 : STW;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    vjtag_uart_bridge_if #(.W(W), .DEPTH(DEPTH)) bus ();
    vjtag_uart_bridge #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .nreset_i(nreset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    logic         m_ovf;
    logic [31:0]  got;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_flags();
        chk("txmt",     32'(bus.txmt),     32'(txq.size() == 0));
        chk("txfl",     32'(bus.txfl),     32'(txq.size() == DEPTH));
        chk("rxmt",     32'(bus.rxmt),     32'(rxq.size() == 0));
        chk("rxfl",     32'(bus.rxfl),     32'(rxq.size() == DEPTH));
        chk("tx_count", 32'(bus.tx_count), 32'(txq.size()));
        chk("rx_count", 32'(bus.rx_count), 32'(rxq.size()));
        chk("rx_ovf",   32'(bus.rx_ovf),   32'(m_ovf));
    endtask

    task automatic chk_reset();
        chk("rst_txmt",  32'(bus.txmt),     32'd1);
        chk("rst_txfl",  32'(bus.txfl),     32'd0);
        chk("rst_rxmt",  32'(bus.rxmt),     32'd1);
        chk("rst_rxfl",  32'(bus.rxfl),     32'd0);
        chk("rst_txcnt", 32'(bus.tx_count), 32'd0);
        chk("rst_rxcnt", 32'(bus.rx_count), 32'd0);
        chk("rst_ovf",   32'(bus.rx_ovf),   32'd0);
        chk("rst_dout",  32'(bus.data_o),   32'd0);
        chk("rst_tdo",   32'(bus.vj_tdo_o), 32'd0);
    endtask

    task automatic host_push(input logic [W-1:0] d);
        bus.nwr_i  = 1'b0;
        bus.data_i = d;
        if (txq.size() < DEPTH) txq.push_back(d);
        @(negedge clk);
        bus.nwr_i = 1'b1;
    endtask

    task automatic host_pop();
        logic [W-1:0] e;
        bus.rd_i = 1'b1;
        @(negedge clk);
        bus.rd_i = 1'b0;
        if (rxq.size() > 0) begin
            e = rxq.pop_front();
            chk("rx_data", 32'(bus.data_o), 32'(e));
        end
    endtask

    // One TCK period; tdo is sampled just before the rising edge. With psh set
    // a host push is aligned to the clock in which the bridge acts on the edge.
    task automatic tck_pulse(input logic cdr, input logic sdr, input logic udr, input logic uir,
                             input logic tdi, input logic psh, input logic [W-1:0] pd,
                             output logic tdo);
        bus.vj_cdr_i = cdr;
        bus.vj_sdr_i = sdr;
        bus.vj_udr_i = udr;
        bus.vj_uir_i = uir;
        bus.vj_tdi_i = tdi;
        bus.vj_tck_i = 1'b0;
        idle(4);
        tdo = bus.vj_tdo_o;
        bus.vj_tck_i = 1'b1;
        idle(2);
        if (psh) begin
            bus.nwr_i  = 1'b0;
            bus.data_i = pd;
        end
        idle(1);
        bus.nwr_i = 1'b1;
        idle(1);
    endtask

    task automatic set_ir(input logic [1:0] code);
        logic b;
        bus.vj_ir_i = code;
        tck_pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, b);
    endtask

    task automatic scan_dr(input int n, input logic [31:0] din, input logic psh,
                           input logic [W-1:0] pd, output logic [31:0] dout);
        logic b;
        dout = '0;
        tck_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, psh, pd, b);
        for (int i = 0; i < n; i++) begin
            tck_pulse(1'b0, 1'b1, 1'b0, 1'b0, din[i], 1'b0, '0, b);
            dout[i] = b;
        end
        tck_pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, b);
        bus.vj_udr_i = 1'b0;
        idle(2);
    endtask

    task automatic tx_scan(input logic psh, input logic [W-1:0] pd);
        logic [31:0] exp, res;
        logic        full_pre;
        full_pre = (txq.size() == DEPTH);
        exp = '0;
        if (txq.size() > 0) begin
            exp[W]     = 1'b1;
            exp[W-1:0] = txq.pop_front();
        end
        if (psh && !full_pre) txq.push_back(pd);
        scan_dr(W + 1, '0, psh, pd, res);
        chk("tx_scan", res, exp);
    endtask

    task automatic rx_scan(input logic v, input logic [W-1:0] d);
        logic [31:0] din, res;
        din        = '0;
        din[W]     = v;
        din[W-1:0] = d;
        if (v) begin
            if (rxq.size() == DEPTH) m_ovf = 1'b1;
            else                     rxq.push_back(d);
        end
        scan_dr(S, din, 1'b0, '0, res);
    endtask

    task automatic status_scan();
        logic [31:0] exp, res;
        exp = '0;
        exp[0]         = (txq.size() == 0);
        exp[1]         = (txq.size() == DEPTH);
        exp[2]         = (rxq.size() == 0);
        exp[3]         = (rxq.size() == DEPTH);
        exp[4]         = m_ovf;
        exp[5+:CW]     = CW'(txq.size());
        exp[5+CW+:CW]  = CW'(rxq.size());
        m_ovf = 1'b0;
        scan_dr(S, '0, 1'b0, '0, res);
        chk("status", res, exp);
    endtask

    initial begin
        bus.nwr_i    = 1'b1;
        bus.data_i   = '0;
        bus.rd_i     = 1'b0;
        bus.vj_tck_i = 1'b0;
        bus.vj_tdi_i = 1'b0;
        bus.vj_ir_i  = 2'b11;
        bus.vj_cdr_i = 1'b0;
        bus.vj_sdr_i = 1'b0;
        bus.vj_udr_i = 1'b0;
        bus.vj_uir_i = 1'b0;
        m_ovf        = 1'b0;
        idle(3);
        nreset = 1'b1;
        idle(2);
        chk_reset();
        chk("ir_pass", 32'(bus.vj_ir_o), 32'd3);

        // Two host words, status, then drain over TX scans
        host_push(8'h41);
        host_push(8'h42);
        idle(1);
        set_ir(2'b10);
        chk("ir_pass2", 32'(bus.vj_ir_o), 32'd2);
        status_scan();
        set_ir(2'b00);
        tx_scan(1'b0, '0);
        tx_scan(1'b0, '0);
        chk_flags();
        tx_scan(1'b0, '0);
        chk_flags();

        // RX valid word, host pop, invalid word
        set_ir(2'b01);
        rx_scan(1'b1, 8'h5A);
        chk_flags();
        host_pop();
        rx_scan(1'b0, 8'hFF);
        chk_flags();

        // Fill RX, overflow, status clears overflow, drain
        for (int i = 0; i < DEPTH; i++) rx_scan(1'b1, W'(i * 7 + 3));
        chk_flags();
        rx_scan(1'b1, 8'hEE);
        chk_flags();
        set_ir(2'b10);
        status_scan();
        chk_flags();
        for (int i = 0; i < DEPTH; i++) host_pop();
        chk_flags();

        // Same-cycle push/pop on TX, push at full, wrap
        set_ir(2'b00);
        for (int i = 0; i < 3; i++) host_push(W'(8'h10 + i));
        for (int i = 0; i < 5; i++) begin
            tx_scan(1'b1, W'(8'h20 + i));
            chk("tx_cnt_same", 32'(bus.tx_count), 32'd3);
        end
        for (int k = 0; k < 2 * DEPTH && txq.size() < DEPTH; k++) host_push(W'(8'h80 + k));
        chk_flags();
        tx_scan(1'b1, 8'hFF);
        chk_flags();
        for (int k = 0; k < 2 * DEPTH && txq.size() > 0; k++) tx_scan(1'b0, '0);
        chk_flags();

        // BYPASS: tdo follows tdi one shift later
        set_ir(2'b11);
        scan_dr(4, 32'h5, 1'b0, '0, got);
        chk("bypass", got, 32'hA);

        // Reset in the middle of a TX scan
        host_push(8'h77);
        set_ir(2'b00);
        begin
            logic b;
            tck_pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, b);
            for (int i = 0; i < 3; i++) tck_pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, b);
        end
        bus.vj_sdr_i = 1'b0;
        bus.vj_tck_i = 1'b0;
        idle(3);
        nreset = 1'b0;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        idle(2);
        chk_reset();
        nreset = 1'b1;
        idle(2);
        chk_flags();
        // Still in BYPASS after reset: second tdo sample echoes the first tdi
        scan_dr(2, 32'h1, 1'b0, '0, got);
        chk("rst_bypass", got, 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
